inv_mix_columns_seq: RTL and testbench
======================================

# inv_mix_columns_seq

Multi-cycle InvMixColumns engine for the AES decryption datapath. It accepts one 128-bit state over a valid/ready handshake and transforms its columns in place with the inverse MixColumns matrix over GF(2^8), COLS_PER_CYCLE columns per clock. It holds the result until the downstream stage accepts it. It is the decrypt-side counterpart of the column mixer in the encryption round and sits between InvShiftRows/InvSubBytes/AddRoundKey in the sequential inverse-cipher round.

## Interface

Parameters:
- COLS_PER_CYCLE, default 1: columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is a compile-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state. High only in IDLE.
- in_data  input  128  input state.
  - Column c occupies bits [127-32c -: 32].
  - Within a column, byte a0 is bits [31:24] and a3 is bits [7:0].
- out_valid  output  1  out_data holds a finished state.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  transformed state, same byte layout as in_data.
- busy  output  1  high in BUSY or DONE.

## Operation

- Per column, b = M·a over GF(2^8) with reduction polynomial 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Build the multipliers from xtime chains. xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 09 = x8^x, 0b = x8^x2^x, 0d = x8^x4^x, 0e = x8^x4^x2.
- No general multiplier. All arithmetic is 8-bit; no carries leave a byte.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the state register, set col_cnt=0, go to BUSY.
  - BUSY: each cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in the state register with their transformed values, and advance col_cnt by COLS_PER_CYCLE.
    - When the last column is written, go to DONE.
    - col_cnt is 2 bits and wraps to 0 on that transition.
  - DONE: out_valid=1; out_data is driven from the state register and stays stable.
    - On out_ready, go to IDLE.
    - While out_ready=0, hold indefinitely with no change to out_data.
- in_data is ignored outside IDLE. in_valid while busy has no effect and needs no buffering.
- A new state is not accepted in the same cycle as the DONE handshake. in_ready rises the cycle after the handshake.

## Timing

- Reset, asynchronous and mid-operation included, forces:
  - state to IDLE, col_cnt=0, state register=0
  - in_ready=1, out_valid=0, busy=0, out_data=128'h0
- Any in-flight block is discarded.
- Latency: accept edge E0. Columns are processed on edges E1..EN, with N = 4/COLS_PER_CYCLE. out_valid is high after EN.
  - Latency is 4, 2 or 1 cycles for COLS_PER_CYCLE = 1, 2, 4.
- Throughput: one state per N+2 cycles when out_ready is held high.
  - The cycles are accept, N BUSY cycles, and DONE handshake; IDLE is re-entered and the next accept can happen on that cycle.
- Outputs are registered or decoded directly from state. There is no combinational path from in_valid or out_ready to any output.
- busy rises on the edge after acceptance and falls on the edge after the DONE handshake.

## Test plan

- Single column vectors, repeated in all four columns, COLS_PER_CYCLE=1. Each input must map to its output:
  - 8e4da1bc -> db135345
  - 9fdc589d -> f20a225c
  - 01010101 -> 01010101
  - c6c6c6c6 -> c6c6c6c6
  - d5d5d7d6 -> d4d4d4d5
  - 4d7ebdf8 -> 2d26314c
- Mixed state in_data = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8 -> out_data = db135345_f20a225c_d4d4d4d5_2d26314c.
  - Run with COLS_PER_CYCLE = 1, 2 and 4.
  - out_valid must rise exactly 4, 2 and 1 cycles after acceptance respectively.
- Round trip: random states passed through the forward column mixer and then this block must return the original state, for at least 1000 vectors.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_data stays stable and in_ready stays 0.
  - in_valid pulses with other data are ignored.
  - Raising out_ready gives one handshake; in_ready=1 on the next cycle.
- Reset mid-operation: assert rst during the second BUSY cycle.
  - Outputs go to their reset values immediately, asynchronously.
  - After release, a new vector 01010101 x4 is processed correctly with no residue from the aborted state.
- Back-to-back streaming with out_ready tied high and in_valid always high: the accept interval is exactly N+2 cycles, and every output matches the model.

Source files
------------

// File: rtl/inv_mix_columns_seq_if.sv
// rtl/inv_mix_columns_seq_if.sv - stream handshake bundle for the InvMixColumns engine
interface inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - multi-cycle AES InvMixColumns engine, COLS_PER_CYCLE columns per clock
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_mix_columns_seq_if.slave  bus
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Column c sits at index c, so index 0 is the most significant word.
    logic [0:3][31:0] data_q, data_d;
    logic [1:0]       col_cnt;
    logic [2:0]       cnt_sum;
    logic             last_step;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // col_cnt only ever holds multiples of COLS_PER_CYCLE, so the sum reaches exactly 4 on the last step.
    assign cnt_sum   = {1'b0, col_cnt} + 3'(COLS_PER_CYCLE);
    assign last_step = (cnt_sum == 3'd4);

    always_comb begin
        data_d = data_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            data_d[col_cnt + 2'(k)] = inv_mix_col(data_q[col_cnt + 2'(k)]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_BUSY;
            ST_BUSY: if (last_step)     state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            col_cnt <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data_q  <= bus.in_data;
                        col_cnt <= 2'd0;
                    end
                end
                ST_BUSY: begin
                    data_q  <= data_d;
                    col_cnt <= cnt_sum[1:0];
                end
                default: ;
            endcase
        end
    end

    // Every output is decoded from registered state; handshake inputs never reach an output combinationally.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - self-checking bench running COLS_PER_CYCLE = 1, 2, 4 side by side
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_mix_columns_seq_if bus1 ();
    inv_mix_columns_seq_if bus2 ();
    inv_mix_columns_seq_if bus4 ();

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [2:0]   ov, ir, bz;
    logic [127:0] od [3];
    assign ov = {bus4.out_valid, bus2.out_valid, bus1.out_valid};
    assign ir = {bus4.in_ready,  bus2.in_ready,  bus1.in_ready};
    assign bz = {bus4.busy,      bus2.busy,      bus1.busy};
    assign od[0] = bus1.out_data;
    assign od[1] = bus2.out_data;
    assign od[2] = bus4.out_data;

    int passed = 0;
    int total  = 0;

    logic [127:0] got  [3];
    int           lat  [3];
    int           back [3];

    localparam logic [31:0] VIN  [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                                         32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
    localparam logic [31:0] VOUT [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                                         32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};

    function automatic int n_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product: row r uses the first row rotated right by r.
    function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inv);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b ^= gf_mul(coef[(k - rr + 4) % 4], a[k]);
                r[127 - 32*c - 8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic v, input logic [127:0] d, input logic r);
        bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = r;
        bus2.in_valid = v; bus2.in_data = d; bus2.out_ready = r;
        bus4.in_valid = v; bus4.in_data = d; bus4.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accept with out_ready high; records result, cycles to out_valid and cycles to in_ready return.
    task automatic run_one(input logic [127:0] d);
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; back[i] = -1; got[i] = '0;
        end
        drive(1'b1, d, 1'b1);
        tick();
        drive(1'b0, d, 1'b1);
        for (int t = 1; t <= 8; t++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && lat[i] < 0) begin
                    lat[i] = t; got[i] = od[i];
                end else if (lat[i] >= 0 && back[i] < 0 && ir[i]) begin
                    back[i] = t;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ir[i], ov[i], bz[i], od[i]} !== {1'b1, 1'b0, 1'b0, 128'h0})
                $display("FAIL reset_state n=%0d got ir=%b ov=%b busy=%b data=%h want 1 0 0 0",
                         n_of(i), ir[i], ov[i], bz[i], od[i]);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ir[i], ov[i], bz[i]} !== 3'b100)
                $display("FAIL post_reset_idle n=%0d got ir=%b ov=%b busy=%b want 1 0 0",
                         n_of(i), ir[i], ov[i], bz[i]);
            else passed++;
        end
    endtask

    task automatic test_vectors();
        for (int v = 0; v < 6; v++) begin
            run_one({4{VIN[v]}});
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== {4{VOUT[v]}})
                    $display("FAIL vector_%h n=%0d got %h want %h", VIN[v], n_of(i), got[i], {4{VOUT[v]}});
                else passed++;
            end
        end
    endtask

    task automatic test_mixed_latency();
        logic [127:0] want;
        want = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        run_one(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== want)
                $display("FAIL mixed_data n=%0d got %h want %h", n_of(i), got[i], want);
            else passed++;
            total++;
            if (lat[i] != n_of(i))
                $display("FAIL mixed_latency n=%0d got %0d want %0d", n_of(i), lat[i], n_of(i));
            else passed++;
            total++;
            if (back[i] != n_of(i) + 1)
                $display("FAIL mixed_ready_return n=%0d got %0d want %0d", n_of(i), back[i], n_of(i) + 1);
            else passed++;
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] s;
        for (int n = 0; n < 1000; n++) begin
            s = rand128();
            run_one(mix_state(s, 1'b0));
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== s)
                    $display("FAIL round_trip n=%0d vec=%0d got %h want %h", n_of(i), n, got[i], s);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s, want;
        s    = rand128();
        want = mix_state(s, 1'b1);
        drive(1'b1, s, 1'b0);
        tick();
        drive(1'b0, s, 1'b0);
        repeat (4) tick();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({ov[i], ir[i], od[i]} !== {1'b1, 1'b0, want})
                    $display("FAIL backpressure_hold n=%0d cyc=%0d got ov=%b ir=%b data=%h want 1 0 %h",
                             n_of(i), c, ov[i], ir[i], od[i], want);
                else passed++;
            end
            drive(1'(c % 2), rand128(), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ov[i], ir[i], bz[i]} !== 3'b010)
                $display("FAIL backpressure_release n=%0d got ov=%b ir=%b busy=%b want 0 1 0",
                         n_of(i), ov[i], ir[i], bz[i]);
            else passed++;
        end
        drive(1'b0, '0, 1'b0);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ov[i], bz[i]} !== 2'b00)
                $display("FAIL backpressure_no_extra n=%0d got ov=%b busy=%b want 0 0", n_of(i), ov[i], bz[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, rand128(), 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ir[i], ov[i], bz[i], od[i]} !== {1'b1, 1'b0, 1'b0, 128'h0})
                $display("FAIL reset_mid n=%0d got ir=%b ov=%b busy=%b data=%h want 1 0 0 0",
                         n_of(i), ir[i], ov[i], bz[i], od[i]);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        run_one({4{32'h01010101}});
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== {4{32'h01010101}} || lat[i] != n_of(i))
                $display("FAIL reset_recover n=%0d got %h lat=%0d want %h lat=%0d",
                         n_of(i), got[i], lat[i], {4{32'h01010101}}, n_of(i));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [3][$];
        int           last_acc [3];
        logic [127:0] d;
        for (int i = 0; i < 3; i++) last_acc[i] = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            d = rand128();
            drive(1'b1, d, 1'b1);
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) begin
                    total++;
                    if (exp_q[i].size() == 0 || od[i] !== exp_q[i][0])
                        $display("FAIL b2b_data n=%0d cyc=%0d got %h want %h", n_of(i), cyc, od[i],
                                 (exp_q[i].size() == 0) ? 128'h0 : exp_q[i][0]);
                    else passed++;
                    if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                end
                if (ir[i]) begin
                    exp_q[i].push_back(mix_state(d, 1'b1));
                    if (last_acc[i] >= 0) begin
                        total++;
                        if (cyc - last_acc[i] != n_of(i) + 2)
                            $display("FAIL b2b_interval n=%0d got %0d want %0d", n_of(i), cyc - last_acc[i], n_of(i) + 2);
                        else passed++;
                    end
                    last_acc[i] = cyc;
                end
            end
            tick();
        end
        drive(1'b0, '0, 1'b1);
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) begin
                    total++;
                    if (exp_q[i].size() == 0 || od[i] !== exp_q[i][0])
                        $display("FAIL b2b_drain n=%0d got %h", n_of(i), od[i]);
                    else passed++;
                    if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (exp_q[i].size() != 0)
                $display("FAIL b2b_pending n=%0d got %0d outstanding want 0", n_of(i), exp_q[i].size());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_mixed_latency();
        test_round_trip();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, %0d/%0d done", passed, total);
        $fatal(1);
    end

endmodule
